// File: rtl/arena_jogadores.sv
// arena_jogadores: multi-player light-cycle engine.
// Owns the arena cell grid (walls and trails), moves NUM_JOG players once
// per game tick, detects wall/trail/head-on collisions and reports status.
// A second, independent grid read port serves per-pixel lookups for the
// VGA colour mixer.
//
// Ports:
//   CLOCK_50            system clock
//   reset               asynchronous, active-high reset
//   reiniciar           synchronous restart (level)
//   turn_cw/turn_ccw    per-player one-cycle turn pulses
//   next_x/next_y       pixel coordinate to look up
//   cell_owner          looked-up cell code (0 empty, k+1 trail, NUM_JOG+1 wall), 1-cycle latency
//   head_hit            looked-up cell is a living player's head, 1-cycle latency
//   ready               grid initialised, game running or finished
//   vivo                per-player alive flags
//   fim_de_jogo         game over
//   vencedor            winner code k+1, 0 for draw / not over
module arena_jogadores #(
    parameter int NUM_JOG   = 2,
    parameter int GRID_W    = 80,
    parameter int GRID_H    = 60,
    parameter int CELL_LOG2 = 3,
    parameter int BORDER    = 2,
    parameter int TICK_DIV  = 800000,
    parameter int OWN_W     = $clog2(NUM_JOG + 2)
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               reiniciar,
    input  logic [NUM_JOG-1:0] turn_cw,
    input  logic [NUM_JOG-1:0] turn_ccw,
    input  logic [9:0]         next_x,
    input  logic [9:0]         next_y,
    output logic [OWN_W-1:0]   cell_owner,
    output logic               head_hit,
    output logic               ready,
    output logic [NUM_JOG-1:0] vivo,
    output logic               fim_de_jogo,
    output logic [OWN_W-1:0]   vencedor
);
    localparam int N_CELLS = GRID_W * GRID_H;
    localparam int CW      = $clog2(GRID_W);
    localparam int RW      = $clog2(GRID_H);
    localparam int AW      = $clog2(N_CELLS);
    localparam int CLR_W   = $clog2(N_CELLS + NUM_JOG + 1);
    localparam int MV_LAST = 3 * NUM_JOG;
    localparam int MW      = $clog2(MV_LAST + 1);
    localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_MOVE  = 2'd2;

    localparam logic [OWN_W-1:0] WALL      = OWN_W'(NUM_JOG + 1);
    localparam logic [RW-1:0]    START_ROW = RW'(GRID_H / 2);

    function automatic logic [NUM_JOG-1:0][CW-1:0] start_cols();
        for (int k = 0; k < NUM_JOG; k++) start_cols[k] = CW'((k + 1) * GRID_W / (NUM_JOG + 1));
    endfunction

    // Even players start heading right (0), odd players left (2).
    function automatic logic [NUM_JOG-1:0][1:0] start_hds();
        for (int k = 0; k < NUM_JOG; k++) start_hds[k] = (k % 2 == 0) ? 2'd0 : 2'd2;
    endfunction

    localparam logic [NUM_JOG-1:0][CW-1:0] START_PX = start_cols();
    localparam logic [NUM_JOG-1:0][1:0]    START_HD = start_hds();

    function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'(r) * AW'(GRID_W) + AW'(c);
    endfunction

    // Valid/ready note: the lookup port has no handshake; a coordinate
    // presented in cycle N is answered in cycle N+1, every cycle.

    logic [1:0]                state_q, state_d;
    logic [CLR_W-1:0]          clr_cnt_q, clr_cnt_d;
    logic [CW-1:0]             clr_col_q, clr_col_d;
    logic [RW-1:0]             clr_row_q, clr_row_d;
    logic [TW-1:0]             tick_q, tick_d;
    logic [MW-1:0]             mv_cnt_q, mv_cnt_d;
    logic [NUM_JOG-1:0][CW-1:0] px_q, px_d, tx_q, tx_d;
    logic [NUM_JOG-1:0][RW-1:0] py_q, py_d, ty_q, ty_d;
    logic [NUM_JOG-1:0][1:0]   hd_q, hd_d;
    logic [NUM_JOG-1:0]        dying_q, dying_d;
    logic                      ready_q, ready_d;
    logic [NUM_JOG-1:0]        vivo_q, vivo_d;
    logic                      fim_q, fim_d;
    logic [OWN_W-1:0]          venc_q, venc_d;
    logic                      pix_ok_q, pix_ok_d;
    logic                      head_q, head_d;

    logic                      eng_we;
    logic [AW-1:0]             eng_addr;
    logic [OWN_W-1:0]          eng_wdata;
    logic [OWN_W-1:0]          eng_rd_q;
    logic [AW-1:0]             pix_addr;
    logic [OWN_W-1:0]          pix_rd_q;
    logic [OWN_W-1:0]          grid_mem [N_CELLS];

    logic [NUM_JOG-1:0]        alive_nx;
    int                        alive_cnt;
    logic [OWN_W-1:0]          winner;
    logic [9:0]                lk_col, lk_row;
    logic                      lk_in;

    // Grid RAM: engine read/write port plus independent pixel read port.
    always_ff @(posedge CLOCK_50) begin
        if (eng_we) grid_mem[eng_addr] <= eng_wdata;
        eng_rd_q <= grid_mem[eng_addr];
        pix_rd_q <= grid_mem[pix_addr];
    end

    // Outcome of the current MOVE once dying players are removed.
    always_comb begin
        alive_nx  = vivo_q & ~dying_q;
        alive_cnt = 0;
        winner    = '0;
        for (int k = 0; k < NUM_JOG; k++) begin
            if (alive_nx[k]) begin
                alive_cnt = alive_cnt + 1;
                winner    = OWN_W'(k + 1);
            end
        end
    end

    // MOVE schedule (mv_cnt): 2k issues the read of player k's target,
    // 2k+1 judges it, 2N is the head-on check, 2N+1+k commits player k.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_col_d = clr_col_q;
        clr_row_d = clr_row_q;
        tick_d    = tick_q;
        mv_cnt_d  = mv_cnt_q;
        px_d      = px_q;
        py_d      = py_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        hd_d      = hd_q;
        dying_d   = dying_q;
        ready_d   = ready_q;
        vivo_d    = vivo_q;
        fim_d     = fim_q;
        venc_d    = venc_q;
        eng_we    = 1'b0;
        eng_addr  = '0;
        eng_wdata = '0;
        if (reiniciar) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            clr_col_d = '0;
            clr_row_d = '0;
            tick_d    = '0;
            mv_cnt_d  = '0;
            px_d      = START_PX;
            py_d      = {NUM_JOG{START_ROW}};
            hd_d      = START_HD;
            dying_d   = '0;
            ready_d   = 1'b0;
            vivo_d    = '0;
            fim_d     = 1'b0;
            venc_d    = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    eng_we    = 1'b1;
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                    if (clr_cnt_q < CLR_W'(N_CELLS)) begin
                        eng_addr = addr_of(clr_row_q, clr_col_q);
                        if (clr_row_q < RW'(BORDER) || clr_row_q >= RW'(GRID_H - BORDER) ||
                            clr_col_q < CW'(BORDER) || clr_col_q >= CW'(GRID_W - BORDER))
                            eng_wdata = WALL;
                        if (clr_col_q == CW'(GRID_W - 1)) begin
                            clr_col_d = '0;
                            clr_row_d = clr_row_q + RW'(1);
                        end else begin
                            clr_col_d = clr_col_q + CW'(1);
                        end
                    end
                    for (int k = 0; k < NUM_JOG; k++) begin
                        if (clr_cnt_q == CLR_W'(N_CELLS + k)) begin
                            eng_addr  = addr_of(START_ROW, START_PX[k]);
                            eng_wdata = OWN_W'(k + 1);
                        end
                    end
                    if (clr_cnt_q == CLR_W'(N_CELLS + NUM_JOG - 1)) begin
                        state_d   = ST_RUN;
                        clr_cnt_d = '0;
                        clr_col_d = '0;
                        clr_row_d = '0;
                        ready_d   = 1'b1;
                        vivo_d    = '1;
                    end
                end
                ST_RUN: begin
                    if (!fim_q) begin
                        tick_d = (tick_q == TW'(TICK_DIV - 1)) ? '0 : tick_q + TW'(1);
                        if (tick_q == TW'(TICK_DIV - 1)) begin
                            state_d  = ST_MOVE;
                            mv_cnt_d = '0;
                            dying_d  = '0;
                            // Targets are frozen here so turns arriving during
                            // MOVE only affect the next tick.
                            for (int k = 0; k < NUM_JOG; k++) begin
                                tx_d[k] = px_q[k];
                                ty_d[k] = py_q[k];
                                case (hd_q[k])
                                    2'd0:    tx_d[k] = px_q[k] + CW'(1);
                                    2'd1:    ty_d[k] = py_q[k] + RW'(1);
                                    2'd2:    tx_d[k] = px_q[k] - CW'(1);
                                    default: ty_d[k] = py_q[k] - RW'(1);
                                endcase
                            end
                        end
                    end
                end
                ST_MOVE: begin
                    tick_d   = (tick_q == TW'(TICK_DIV - 1)) ? '0 : tick_q + TW'(1);
                    mv_cnt_d = mv_cnt_q + MW'(1);
                    for (int k = 0; k < NUM_JOG; k++) begin
                        if (mv_cnt_q == MW'(2 * k))
                            eng_addr = addr_of(ty_q[k], tx_q[k]);
                        if (mv_cnt_q == MW'(2 * k + 1) && vivo_q[k] && eng_rd_q != '0)
                            dying_d[k] = 1'b1;
                        if (mv_cnt_q == MW'(2 * NUM_JOG + 1 + k) && vivo_q[k] && !dying_q[k]) begin
                            eng_we    = 1'b1;
                            eng_addr  = addr_of(ty_q[k], tx_q[k]);
                            eng_wdata = OWN_W'(k + 1);
                            px_d[k]   = tx_q[k];
                            py_d[k]   = ty_q[k];
                        end
                    end
                    if (mv_cnt_q == MW'(2 * NUM_JOG)) begin
                        for (int i = 0; i < NUM_JOG; i++) begin
                            for (int j = i + 1; j < NUM_JOG; j++) begin
                                if (vivo_q[i] && vivo_q[j] && tx_q[i] == tx_q[j] && ty_q[i] == ty_q[j]) begin
                                    dying_d[i] = 1'b1;
                                    dying_d[j] = 1'b1;
                                end
                            end
                        end
                    end
                    if (mv_cnt_q == MW'(MV_LAST)) begin
                        state_d  = ST_RUN;
                        mv_cnt_d = '0;
                        vivo_d   = alive_nx;
                        if (alive_cnt <= 1) begin
                            fim_d  = 1'b1;
                            venc_d = (alive_cnt == 1) ? winner : '0;
                        end
                    end
                end
                default: state_d = ST_CLEAR;
            endcase
            if (state_q == ST_RUN || state_q == ST_MOVE) begin
                for (int k = 0; k < NUM_JOG; k++) begin
                    if (vivo_q[k] && (turn_cw[k] ^ turn_ccw[k]))
                        hd_d[k] = turn_cw[k] ? hd_q[k] + 2'd1 : hd_q[k] - 2'd1;
                end
            end
        end
    end

    // Pixel lookup: cell coordinate, range check and head match.
    always_comb begin
        lk_col   = next_x >> CELL_LOG2;
        lk_row   = next_y >> CELL_LOG2;
        lk_in    = (lk_col < 10'(GRID_W)) && (lk_row < 10'(GRID_H));
        pix_addr = lk_in ? addr_of(lk_row[RW-1:0], lk_col[CW-1:0]) : '0;
        pix_ok_d = lk_in && ready_q;
        head_d   = 1'b0;
        for (int k = 0; k < NUM_JOG; k++) begin
            if (pix_ok_d && vivo_q[k] && px_q[k] == lk_col[CW-1:0] && py_q[k] == lk_row[RW-1:0])
                head_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            clr_col_q <= '0;
            clr_row_q <= '0;
            tick_q    <= '0;
            mv_cnt_q  <= '0;
            px_q      <= START_PX;
            py_q      <= {NUM_JOG{START_ROW}};
            tx_q      <= START_PX;
            ty_q      <= {NUM_JOG{START_ROW}};
            hd_q      <= START_HD;
            dying_q   <= '0;
            ready_q   <= 1'b0;
            vivo_q    <= '0;
            fim_q     <= 1'b0;
            venc_q    <= '0;
            pix_ok_q  <= 1'b0;
            head_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            clr_col_q <= clr_col_d;
            clr_row_q <= clr_row_d;
            tick_q    <= tick_d;
            mv_cnt_q  <= mv_cnt_d;
            px_q      <= px_d;
            py_q      <= py_d;
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            hd_q      <= hd_d;
            dying_q   <= dying_d;
            ready_q   <= ready_d;
            vivo_q    <= vivo_d;
            fim_q     <= fim_d;
            venc_q    <= venc_d;
            pix_ok_q  <= pix_ok_d;
            head_q    <= head_d;
        end
    end

    assign cell_owner  = pix_ok_q ? pix_rd_q : '0;
    assign head_hit    = head_q;
    assign ready       = ready_q;
    assign vivo        = vivo_q;
    assign fim_de_jogo = fim_q;
    assign vencedor    = venc_q;
endmodule

// File: tb/tb_arena_jogadores.sv
// tb_arena_jogadores: scoreboard bench for arena_jogadores (2 players,
// 16-cycle ticks). A grid-level game model predicts lookups and status.
module tb_arena_jogadores;
    localparam int NJ = 2;
    localparam int GW = 80;
    localparam int GH = 60;
    localparam int TD = 16;
    localparam int OW = $clog2(NJ + 2);

    logic          clk = 1'b0;
    logic          reset;
    logic          reiniciar;
    logic [NJ-1:0] turn_cw, turn_ccw;
    logic [9:0]    next_x, next_y;
    logic [OW-1:0] cell_owner;
    logic          head_hit;
    logic          ready;
    logic [NJ-1:0] vivo;
    logic          fim_de_jogo;
    logic [OW-1:0] vencedor;

    always #5 clk = ~clk;

    arena_jogadores #(.NUM_JOG(NJ), .GRID_W(GW), .GRID_H(GH), .CELL_LOG2(3),
                      .BORDER(2), .TICK_DIV(TD)) dut (
        .CLOCK_50(clk), .reset(reset), .reiniciar(reiniciar),
        .turn_cw(turn_cw), .turn_ccw(turn_ccw),
        .next_x(next_x), .next_y(next_y),
        .cell_owner(cell_owner), .head_hit(head_hit), .ready(ready),
        .vivo(vivo), .fim_de_jogo(fim_de_jogo), .vencedor(vencedor)
    );

    int total = 0;
    int bad   = 0;
    logic [OW:0] exp_q[$];
    int          xy_q[$];
    logic        lk_req = 1'b0;

    // ---------------- reference model ----------------
    int mg[GH][GW];
    int mpx[NJ], mpy[NJ], mhd[NJ];
    bit mal[NJ];
    bit mfim;
    int mvenc;
    int dxs[4] = '{1, 0, -1, 0};
    int dys[4] = '{0, 1, 0, -1};

    function automatic void model_init();
        for (int r = 0; r < GH; r++)
            for (int c = 0; c < GW; c++)
                mg[r][c] = (r < 2 || r >= GH - 2 || c < 2 || c >= GW - 2) ? NJ + 1 : 0;
        for (int k = 0; k < NJ; k++) begin
            mpx[k] = (k + 1) * GW / (NJ + 1);
            mpy[k] = GH / 2;
            mhd[k] = (k % 2 == 0) ? 0 : 2;
            mg[mpy[k]][mpx[k]] = k + 1;
            mal[k] = 1'b1;
        end
        mfim  = 1'b0;
        mvenc = 0;
    endfunction

    function automatic void model_turn(int k, bit cw, bit ccw);
        if (mal[k] && cw != ccw) mhd[k] = (mhd[k] + (cw ? 1 : 3)) % 4;
    endfunction

    function automatic void model_tick();
        int tx[NJ], ty[NJ];
        bit dy[NJ];
        int n;
        if (mfim) return;
        for (int k = 0; k < NJ; k++) begin
            tx[k] = mpx[k] + dxs[mhd[k]];
            ty[k] = mpy[k] + dys[mhd[k]];
            dy[k] = mal[k] && (mg[ty[k]][tx[k]] != 0);
        end
        for (int i = 0; i < NJ; i++)
            for (int j = i + 1; j < NJ; j++)
                if (mal[i] && mal[j] && tx[i] == tx[j] && ty[i] == ty[j]) begin
                    dy[i] = 1'b1;
                    dy[j] = 1'b1;
                end
        n = 0;
        for (int k = 0; k < NJ; k++) begin
            if (mal[k] && !dy[k]) begin
                mg[ty[k]][tx[k]] = k + 1;
                mpx[k] = tx[k];
                mpy[k] = ty[k];
            end
            if (dy[k]) mal[k] = 1'b0;
            if (mal[k]) n++;
        end
        if (n <= 1) begin
            mfim  = 1'b1;
            mvenc = 0;
            for (int k = 0; k < NJ; k++) if (mal[k]) mvenc = k + 1;
        end
    endfunction

    function automatic void model_run();
        for (int g = 0; g < 1000 && !mfim; g++) model_tick();
    endfunction

    function automatic logic [OW:0] model_look(int x, int y);
        int c, r, own;
        bit hd;
        c = x >> 3;
        r = y >> 3;
        own = 0;
        hd = 1'b0;
        if (c < GW && r < GH) begin
            own = mg[r][c];
            for (int k = 0; k < NJ; k++) if (mal[k] && mpx[k] == c && mpy[k] == r) hd = 1'b1;
        end
        return {hd, OW'(own)};
    endfunction

    function automatic int model_vivo();
        int v = 0;
        for (int k = 0; k < NJ; k++) if (mal[k]) v |= (1 << k);
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: a lookup presented before a rising edge is answered after it.
    initial begin
        logic        pend;
        logic [OW:0] e;
        int          xy;
        forever begin
            @(posedge clk);
            pend = lk_req;
            @(negedge clk);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    check("lookup_queue_underflow", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    xy = xy_q.pop_front();
                    check($sformatf("owner(%0d,%0d)", xy >> 16, xy & 16'hffff), int'(cell_owner), int'(e[OW-1:0]));
                    check($sformatf("head(%0d,%0d)", xy >> 16, xy & 16'hffff), int'(head_hit), int'(e[OW]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic lookup(input int x, input int y);
        next_x = 10'(x);
        next_y = 10'(y);
        lk_req = 1'b1;
        exp_q.push_back(model_look(x, y));
        xy_q.push_back((x << 16) | y);
        @(negedge clk);
        lk_req = 1'b0;
    endtask

    task automatic check_row(input int r);
        for (int c = 0; c < GW; c++) lookup(c * 8 + 3, r * 8 + 5);
    endtask

    task automatic check_col(input int c);
        for (int r = 0; r < GH; r++) lookup(c * 8 + 1, r * 8 + 2);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_vivo"}, int'(vivo), model_vivo());
        check({tag, "_fim"}, int'(fim_de_jogo), int'(mfim));
        check({tag, "_vencedor"}, int'(vencedor), mvenc);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_owner"}, int'(cell_owner), 0);
        check({tag, "_head"}, int'(head_hit), 0);
        check({tag, "_ready"}, int'(ready), 0);
        check({tag, "_vivo"}, int'(vivo), 0);
        check({tag, "_fim"}, int'(fim_de_jogo), 0);
        check({tag, "_vencedor"}, int'(vencedor), 0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (n < 6000 && ready !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_clear_cycles"}, n, GW * GH + NJ);
        model_init();
    endtask

    task automatic wait_fim(input string tag);
        int n = 0;
        while (n < 8000 && fim_de_jogo !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_game_over_seen"}, int'(fim_de_jogo), 1);
        model_run();
    endtask

    task automatic do_restart(input string tag);
        reiniciar = 1'b1;
        @(negedge clk);
        reiniciar = 1'b0;
        check({tag, "_restart_ready"}, int'(ready), 0);
        check({tag, "_restart_vivo"}, int'(vivo), 0);
        check({tag, "_restart_fim"}, int'(fim_de_jogo), 0);
        check({tag, "_restart_venc"}, int'(vencedor), 0);
        wait_ready(tag);
        check({tag, "_vivo_start"}, int'(vivo), (1 << NJ) - 1);
    endtask

    task automatic init_lookups();
        lookup(0, 0);
        lookup(208, 240);
        lookup(424, 240);
        lookup(100, 100);
        lookup(639, 479);
        lookup(640, 0);
        lookup(0, 480);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int found;
        logic [NJ-1:0] cw, ccw;
        reset = 1'b1;
        reiniciar = 1'b0;
        turn_cw = '0;
        turn_ccw = '0;
        next_x = '0;
        next_y = '0;
        model_init();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Initialisation, then straight-line head-on draw.
        wait_ready("init");
        check("init_vivo", int'(vivo), 3);
        init_lookups();
        wait_fim("noturn");
        check_status("noturn");
        check_row(30);
        check_row(31);

        // Player 0 turns down before tick 1; player 1 hits its start cell.
        do_restart("turn");
        turn_cw = 2'b01;
        model_turn(0, 1'b1, 1'b0);
        @(negedge clk);
        turn_cw = '0;
        wait_fim("turn");
        check_status("turn");
        check_col(26);
        check_row(30);
        repeat (50) @(negedge clk);
        check("turn_frozen_fim", int'(fim_de_jogo), 1);
        lookup(26 * 8, 57 * 8);

        // cw and ccw together on player 1: no heading change.
        do_restart("both");
        turn_cw = 2'b10;
        turn_ccw = 2'b10;
        model_turn(1, 1'b1, 1'b1);
        @(negedge clk);
        turn_cw = '0;
        turn_ccw = '0;
        wait_fim("both");
        check_status("both");
        check_row(30);

        // Restart in the middle of tick 5's MOVE.
        do_restart("mid");
        next_x = 10'(31 * 8);
        next_y = 10'(240);
        found = 0;
        for (int n = 0; n < 400 && found == 0; n++) begin
            @(negedge clk);
            if (cell_owner == OW'(1)) found = 1;
        end
        check("mid_tick5_seen", found, 1);
        do_restart("mid");
        for (int c = 27; c <= 31; c++) lookup(c * 8, 240);
        for (int c = 49; c <= 52; c++) lookup(c * 8, 240);
        lookup(208, 240);
        lookup(424, 240);

        // Async reset mid-game, then again mid-clear.
        repeat (20) @(negedge clk);
        next_x = 10'd0;
        next_y = 10'd0;
        @(negedge clk);
        check("pre_reset_owner", int'(cell_owner), NJ + 1);
        check("pre_reset_ready", int'(ready), 1);
        #2 reset = 1'b1;
        #1 check_all_zero("async_game");
        @(negedge clk);
        reset = 1'b0;
        repeat (1000) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("async_clear");
        @(negedge clk);
        reset = 1'b0;
        wait_ready("async");
        init_lookups();

        // Randomised rounds: random turn pulses before tick 1.
        for (int round = 0; round < 3; round++) begin
            do_restart("rnd");
            for (int i = 0; i < 6; i++) begin
                cw  = NJ'($urandom_range(0, 3));
                ccw = NJ'($urandom_range(0, 3));
                turn_cw = cw;
                turn_ccw = ccw;
                for (int k = 0; k < NJ; k++) model_turn(k, cw[k], ccw[k]);
                @(negedge clk);
            end
            turn_cw = '0;
            turn_ccw = '0;
            wait_fim("rnd");
            check_status("rnd");
            for (int k = 0; k < NJ; k++) lookup(mpx[k] * 8 + 4, mpy[k] * 8 + 4);
            for (int i = 0; i < 30; i++) lookup($urandom_range(0, 700), $urandom_range(0, 520));
            check_row(30);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
